// File: rtl/gf2m_pe_pkg.sv
// Shared types and constants for the GF(2^m) systolic row processing element.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package gf2m_pe_pkg;

  // Default datapath shape: 32-bit digits, 6 beats covers a 163-bit operand.
  localparam int DEFAULT_DIGITS     = 32;
  localparam int DEFAULT_NUM_DIGITS = 6;

  // Bit positions inside the sticky err vector.
  localparam int ERR_LEN   = 0;
  localparam int ERR_PROTO = 1;

  // Stream framing state of one PE.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no B digit held yet
    LOADED = 2'd1,  // B digit held, waiting for a first beat
    RUN    = 2'd2,  // inside a stream, carry is live
    DRAIN  = 2'd3   // emitting the trailing carry digit
  } pe_state_t;

endpackage

// File: rtl/gf2m_clmul_core.sv
// Carry-less (GF(2) polynomial) DIGITS x DIGITS multiplier, 2*DIGITS-1 bit product.
// Latency: purely combinational.
// Backpressure: none.
// Ports: a, b - operand digits; p - unreduced polynomial product.
module gf2m_clmul_core
  import gf2m_pe_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS
) (
  input  logic [DIGITS-1:0]   a,
  input  logic [DIGITS-1:0]   b,
  output logic [2*DIGITS-2:0] p
);

  // Shift-and-XOR over the bits of b; XOR replaces addition so no carries ripple.
  always_comb begin
    p = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[i]) begin
        p = p ^ ({{(DIGITS-1){1'b0}}, a} << i);
      end
    end
  end

endmodule

// File: rtl/gf2m_clmul_row_pe.sv
// Digit-serial GF(2^m) systolic row PE: holds one B digit, streams A digits, accumulates
// clmul partial products with a digit-to-digit carry and appends one carry-drain beat.
// Latency: 1 cycle input beat -> output beat; drain beat follows the last output beat.
// Backpressure: none; in_valid=0 beats are bubbles, illegal beats are dropped and flagged.
// Optional build macro GF2M_PE_PARITY_EN: registers acc_out parity and checks acc_par_in.
// Ports:
//   clk, rstn                  clock, async active-low reset
//   b_load, b_in               B digit load; forwarded as b_load_out/b_out one cycle later
//   in_valid/first/last, a_in  A beat framing and digit
//   acc_in, acc_par_in         upstream partial-sum digit and its parity
//   out_valid/first/last       output framing (out_last marks the drain beat)
//   a_out, acc_out, acc_par_out forwarded A digit, accumulated digit, its parity
//   busy                       stream in progress (RUN or DRAIN)
//   err                        sticky [0] length overrun, [1] protocol violation
module gf2m_clmul_row_pe
  import gf2m_pe_pkg::*;
#(
  parameter int DIGITS     = DEFAULT_DIGITS,
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int CNT_W      = $clog2(NUM_DIGITS + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              b_load,
  input  logic [DIGITS-1:0] b_in,
  input  logic              in_valid,
  input  logic              in_first,
  input  logic              in_last,
  input  logic [DIGITS-1:0] a_in,
  input  logic [DIGITS-1:0] acc_in,
  input  logic              acc_par_in,
  output logic              b_load_out,
  output logic [DIGITS-1:0] b_out,
  output logic              out_valid,
  output logic              out_first,
  output logic              out_last,
  output logic [DIGITS-1:0] a_out,
  output logic [DIGITS-1:0] acc_out,
  output logic              acc_par_out,
  output logic              busy,
  output logic [1:0]        err
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_DIGITS);

  pe_state_t         state;
  pe_state_t         state_nxt;
  logic [DIGITS-1:0] b_hold;
  logic [DIGITS-2:0] carry;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [1:0]        err_q;

  logic              accept;     // beat is consumed this cycle
  logic              restart;    // beat opens a stream: carry-in forced to 0
  logic              drain;      // this cycle emits the trailing carry digit
  logic              proto_hit;  // protocol violation seen this cycle
  logic              len_hit;    // beat reaches NUM_DIGITS without in_last
  logic              b_take;     // b_hold captures b_in this cycle

  logic [2*DIGITS-2:0] prod;
  logic [DIGITS-2:0]   carry_in;
  logic [DIGITS-1:0]   acc_nxt;

  gf2m_clmul_core #(.DIGITS(DIGITS)) u_core (
    .a (a_in),
    .b (b_hold),
    .p (prod)
  );

  // ---------------------------------------------------------------------------
  // Framing FSM: next state and per-cycle decisions.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    restart   = 1'b0;
    proto_hit = 1'b0;
    len_hit   = 1'b0;
    b_take    = 1'b0;
    cnt_nxt   = cnt;
    drain     = (state == DRAIN);

    case (state)
      IDLE: begin
        if (b_load) begin
          b_take    = 1'b1;
          state_nxt = LOADED;
        end
        if (in_valid) begin
          proto_hit = 1'b1;
        end
      end
      LOADED: begin
        b_take = b_load;
        if (in_valid) begin
          if (in_first) begin
            accept  = 1'b1;
            restart = 1'b1;
          end else begin
            proto_hit = 1'b1;
          end
        end
      end
      RUN: begin
        // B must stay stable across a stream; a late load is refused.
        if (b_load) begin
          proto_hit = 1'b1;
        end
        if (in_valid) begin
          accept = 1'b1;
          // A first beat inside a stream abandons the old one and restarts.
          if (in_first) begin
            restart   = 1'b1;
            proto_hit = 1'b1;
          end
        end
      end
      DRAIN: begin
        b_take    = b_load;
        state_nxt = LOADED;
        if (in_valid) begin
          proto_hit = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Common handling for every consumed beat, whatever state accepted it.
    if (accept) begin
      cnt_nxt   = restart ? CNT_W'(1) : cnt + CNT_W'(1);
      len_hit   = !in_last && (cnt_nxt == CNT_MAX);
      state_nxt = (in_last || len_hit) ? DRAIN : RUN;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);

  // ---------------------------------------------------------------------------
  // Beat arithmetic. The upper product half becomes the carry into the next
  // digit; the drain beat flushes it with the upper bit zero-filled.
  // ---------------------------------------------------------------------------
  assign carry_in = restart ? '0 : carry;
  assign acc_nxt  = drain ? {1'b0, carry}
                          : (acc_in ^ prod[DIGITS-1:0] ^ {1'b0, carry_in});

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_hold     <= '0;
      carry      <= '0;
      cnt        <= '0;
      err_q      <= '0;
      b_load_out <= 1'b0;
      b_out      <= '0;
      out_valid  <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      a_out      <= '0;
      acc_out    <= '0;
    end else begin
      // B travels down the row every cycle regardless of local state.
      b_load_out <= b_load;
      b_out      <= b_in;

      if (b_take) begin
        b_hold <= b_in;
      end

      if (len_hit) begin
        err_q[ERR_LEN] <= 1'b1;
      end
      if (proto_hit) begin
        err_q[ERR_PROTO] <= 1'b1;
      end

      if (accept) begin
        carry     <= prod[2*DIGITS-2:DIGITS];
        cnt       <= cnt_nxt;
        out_valid <= 1'b1;
        out_first <= in_first;
        out_last  <= 1'b0;
        a_out     <= a_in;
        acc_out   <= acc_nxt;
      end else if (drain) begin
        carry     <= '0;
        cnt       <= '0;
        out_valid <= 1'b1;
        out_first <= 1'b0;
        out_last  <= 1'b1;
        a_out     <= '0;
        acc_out   <= acc_nxt;
      end else begin
        // Bubble or idle: carry and count hold, data outputs keep last value.
        out_valid <= 1'b0;
        out_first <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

`ifdef GF2M_PE_PARITY_EN
  logic acc_par_q;
  logic par_err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_par_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      if (accept || drain) begin
        acc_par_q <= ^acc_nxt;
      end
      if (accept && (acc_par_in != ^acc_in)) begin
        par_err_q <= 1'b1;
      end
    end
  end

  assign acc_par_out     = acc_par_q;
  // Upstream parity faults surface through the protocol-error bit.
  assign err[ERR_LEN]   = err_q[ERR_LEN];
  assign err[ERR_PROTO] = err_q[ERR_PROTO] | par_err_q;
`else
  logic unused_par;
  assign unused_par      = acc_par_in;
  assign acc_par_out     = 1'b0;
  assign err[ERR_LEN]   = err_q[ERR_LEN];
  assign err[ERR_PROTO] = err_q[ERR_PROTO];
`endif

endmodule

// File: tb/tb_gf2m_clmul_row_pe.sv
// Testbench for gf2m_clmul_row_pe at DIGITS=4, NUM_DIGITS=3.
// Expected beats come from a whole-stream polynomial product model pushed into a queue;
// a forked monitor pops and compares every valid output beat.
module tb_gf2m_clmul_row_pe;

  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rstn;
  logic         b_load;
  logic [D-1:0] b_in;
  logic         in_valid;
  logic         in_first;
  logic         in_last;
  logic [D-1:0] a_in;
  logic [D-1:0] acc_in;
  logic         acc_par_in;
  logic         b_load_out;
  logic [D-1:0] b_out;
  logic         out_valid;
  logic         out_first;
  logic         out_last;
  logic [D-1:0] a_out;
  logic [D-1:0] acc_out;
  logic         acc_par_out;
  logic         busy;
  logic [1:0]   err;

  gf2m_clmul_row_pe #(.DIGITS(D), .NUM_DIGITS(3)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .b_load      (b_load),
    .b_in        (b_in),
    .in_valid    (in_valid),
    .in_first    (in_first),
    .in_last     (in_last),
    .a_in        (a_in),
    .acc_in      (acc_in),
    .acc_par_in  (acc_par_in),
    .b_load_out  (b_load_out),
    .b_out       (b_out),
    .out_valid   (out_valid),
    .out_first   (out_first),
    .out_last    (out_last),
    .a_out       (a_out),
    .acc_out     (acc_out),
    .acc_par_out (acc_par_out),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [D-1:0] acc;
    logic [D-1:0] a;
    logic         first;
    logic         last;
  } exp_t;

  exp_t         exp_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [D-1:0] st_a[0:7];
  logic [D-1:0] st_b[0:7];
  logic [D-1:0] st_acc[0:7];
  logic [D-1:0] cur_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Polynomial product over GF(2).
  function automatic logic [31:0] clmul(input logic [D-1:0] x, input logic [D-1:0] y);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < D; i++) if (y[i]) r = r ^ (32'(x) << i);
    return r;
  endfunction

  // Whole stream as one polynomial: sum_k a_k*b_k*x^(kD). Output digit k is that
  // product's digit k XOR acc_k; the drain beat is the digit just above the stream.
  task automatic push_model(input int n, input bit with_drain);
    logic [31:0] prod;
    exp_t e;
    prod = '0;
    for (int k = 0; k < n; k++) prod = prod ^ (clmul(st_a[k], st_b[k]) << (D * k));
    for (int k = 0; k < n; k++) begin
      e.acc = st_acc[k] ^ prod[D*k +: D];
      e.a = st_a[k];
      e.first = (k == 0);
      e.last = 1'b0;
      exp_q.push_back(e);
    end
    if (with_drain) begin
      e.acc = prod[D*n +: D];
      e.a = '0;
      e.first = 1'b0;
      e.last = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {28'd0, acc_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("acc_out", acc_out, e.acc);
          chk("a_out", a_out, e.a);
          chk("out_first", out_first, e.first);
          chk("out_last", out_last, e.last);
`ifdef GF2M_PE_PARITY_EN
          chk("acc_par_out", acc_par_out, ^e.acc);
`else
          chk("acc_par_out", acc_par_out, 1'b0);
`endif
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic [D-1:0] a, input logic [D-1:0] acc, input bit first,
                      input bit last, input bit bl, input logic [D-1:0] bv, input bit bad_par);
    in_valid = 1'b1;
    a_in = a;
    acc_in = acc;
    acc_par_in = (^acc) ^ bad_par;
    in_first = first;
    in_last = last;
    b_load = bl;
    b_in = bv;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last = 1'b0;
    b_load = 1'b0;
  endtask

  task automatic load_b(input logic [D-1:0] v);
    b_load = 1'b1;
    b_in = v;
    @(posedge clk);
    #1;
    chk("b_out", b_out, v);
    chk("b_load_out", b_load_out, 1'b1);
    b_load = 1'b0;
    cur_b = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One stream of n beats with the current B digit, random data and bubbles.
  task automatic rand_stream(input int n);
    for (int k = 0; k < n; k++) begin
      st_a[k] = 4'($urandom);
      st_acc[k] = 4'($urandom);
      st_b[k] = cur_b;
    end
    push_model(n, 1'b1);
    for (int k = 0; k < n; k++) begin
      beat(st_a[k], st_acc[k], k == 0, k == n - 1, 1'b0, 4'h0, 1'b0);
      if (k < n - 1) idle($urandom_range(0, 2));
    end
    idle(3);
  endtask

  initial begin
    rstn = 1'b0;
    b_load = 1'b0;
    b_in = '0;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last = 1'b0;
    a_in = '0;
    acc_in = '0;
    acc_par_in = 1'b0;
    cur_b = '0;
    fork
      monitor();
    join_none

    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_acc_out", acc_out, 4'h0);
    chk("rst_a_out", a_out, 4'h0);
    chk("rst_b_out", b_out, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 2'b00);
    #9;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Beat in IDLE: dropped and flagged.
    beat(4'h3, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    idle(2);
    chk("idle_beat_err", err, 2'b10);
    do_reset();

    // Single-beat stream, then accumulate with acc_in=0xA.
    load_b(4'h3);
    st_a[0] = 4'hF; st_acc[0] = 4'h0; st_b[0] = 4'h3;
    push_model(1, 1'b1);
    beat(4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    chk("busy_single", busy, 1'b1);
    idle(3);
    chk("busy_after_single", busy, 1'b0);
    st_acc[0] = 4'hA;
    push_model(1, 1'b1);
    beat(4'hF, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    idle(3);

    // Two beats with a bubble between them.
    load_b(4'h2);
    st_a[0] = 4'h8; st_a[1] = 4'h8; st_acc[0] = 4'h0; st_acc[1] = 4'h0;
    st_b[0] = 4'h2; st_b[1] = 4'h2;
    push_model(2, 1'b1);
    beat(4'h8, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    idle(1);
    chk("busy_bubble", busy, 1'b1);
    beat(4'h8, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    idle(3);
    chk("clean_err", err, 2'b00);

    // Overrun: four beats without in_last; the fourth lands in DRAIN.
    load_b(4'h1);
    for (int k = 0; k < 3; k++) begin
      st_a[k] = 4'h5; st_acc[k] = 4'h0; st_b[k] = 4'h1;
    end
    push_model(3, 1'b1);
    for (int k = 0; k < 4; k++) beat(4'h5, 4'h0, k == 0, 1'b0, 1'b0, 4'h0, 1'b0);
    idle(3);
    chk("overrun_err", err, 2'b11);
    do_reset();

    // b_load during RUN is refused; the stream and the next one keep the old B.
    load_b(4'h6);
    st_a[0] = 4'h3; st_a[1] = 4'h5; st_a[2] = 4'h7;
    st_acc[0] = 4'h1; st_acc[1] = 4'h2; st_acc[2] = 4'h4;
    for (int k = 0; k < 3; k++) st_b[k] = 4'h6;
    push_model(3, 1'b1);
    beat(4'h3, 4'h1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    beat(4'h5, 4'h2, 1'b0, 1'b0, 1'b1, 4'hF, 1'b0);
    beat(4'h7, 4'h4, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    idle(3);
    chk("bload_run_err", err, 2'b10);
    st_a[0] = 4'h9; st_acc[0] = 4'h0;
    push_model(1, 1'b1);
    beat(4'h9, 4'h0, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    idle(3);
    do_reset();

    // in_first inside a stream restarts it with a zero carry-in.
    load_b(4'h5);
    st_a[0] = 4'hE; st_acc[0] = 4'h3; st_b[0] = 4'h5;
    push_model(1, 1'b0);
    st_a[0] = 4'hB; st_acc[0] = 4'h6;
    push_model(1, 1'b1);
    beat(4'hE, 4'h3, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    beat(4'hB, 4'h6, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0);
    idle(3);
    chk("restart_err", err, 2'b10);
    do_reset();

    // b_load together with the first beat in LOADED: new B only from beat 2.
    load_b(4'h3);
    st_a[0] = 4'hD; st_a[1] = 4'h6; st_acc[0] = 4'h2; st_acc[1] = 4'h9;
    st_b[0] = 4'h3; st_b[1] = 4'h9;
    push_model(2, 1'b1);
    beat(4'hD, 4'h2, 1'b1, 1'b0, 1'b1, 4'h9, 1'b0);
    beat(4'h6, 4'h9, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0);
    idle(3);
    chk("same_cycle_load_err", err, 2'b00);
    cur_b = 4'h9;

    // Random legal streams.
    for (int s = 0; s < 25; s++) begin
      load_b(4'($urandom));
      rand_stream($urandom_range(1, 3));
    end
    chk("random_err", err, 2'b00);

`ifdef GF2M_PE_PARITY_EN
    load_b(4'h3);
    st_a[0] = 4'hF; st_acc[0] = 4'hA; st_b[0] = 4'h3;
    push_model(1, 1'b1);
    beat(4'hF, 4'hA, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1);
    idle(3);
    chk("parity_err", err, 2'b10);
    do_reset();
`endif

    // Reset mid-stream: outputs clear at once and no drain beat follows.
    load_b(4'h3);
    st_a[0] = 4'hF; st_acc[0] = 4'h0; st_b[0] = 4'h3;
    push_model(1, 1'b0);
    beat(4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0);
    @(negedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_acc_out", acc_out, 4'h0);
    chk("midrst_a_out", a_out, 4'h0);
    chk("midrst_out_first", out_first, 1'b0);
    chk("midrst_b_load_out", b_load_out, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    idle(4);
    chk("post_rst_busy", busy, 1'b0);
    chk("queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gf2m_clmul_row_pe.md
Name: gf2m_clmul_row_pe

Overview:
Parametrised successor PE for the digit-serial GF(2^m) systolic multiplier. It holds one B digit and streams A digits through. For each A beat it forms the carry-less product and XORs it into the accumulator stream with a digit-to-digit carry, then forwards A, B and the control tags to the next PE. Modular reduction stays downstream. This block adds the following, which the previous PE lacked:
- valid/first/last framing
- bubble tolerance
- a trailing carry-drain beat
- length and protocol error detection

Parameters:
DIGITS, 32, digit width in bits (>=2)
NUM_DIGITS, 6, maximum A beats per stream (163-bit operand at 32-bit digits)
CNT_W, $clog2(NUM_DIGITS+1), beat counter width (derived)

Ports:
clk  input  1  clock
rstn  input  1  asynchronous active-low reset
b_load  input  1  load b_in into B hold register
b_in  input  DIGITS  B digit
in_valid  input  1  A beat valid
in_first  input  1  first beat of stream
in_last  input  1  last beat of stream
a_in  input  DIGITS  A digit
acc_in  input  DIGITS  upstream partial-sum digit, aligned with a_in
acc_par_in  input  1  parity of acc_in (used only with the optional feature)
b_load_out  output  1  b_load delayed 1 cycle
b_out  output  DIGITS  b_in delayed 1 cycle
out_valid  output  1  output beat valid
out_first  output  1  first output beat
out_last  output  1  last output beat (drain beat)
a_out  output  DIGITS  a_in delayed 1 cycle (0 on drain beat)
acc_out  output  DIGITS  accumulated digit
acc_par_out  output  1  parity of acc_out
busy  output  1  state is RUN or DRAIN
err  output  2  sticky: [0] length overrun, [1] protocol violation

Behaviour:
- Reset (async, rstn=0):
  - all outputs, b_hold, carry and counter go to 0
  - state goes to IDLE
  - reset mid-stream discards the stream and emits no drain beat
- States: IDLE, LOADED, RUN, DRAIN.
- b_load while not in RUN:
  - b_hold <= b_in
  - IDLE->LOADED; LOADED stays LOADED
- b_load in RUN: ignored; sets err[1]. b_load_out and b_out forward every cycle regardless of state.
- Beat arithmetic, for every accepted beat:
  - p = clmul(a_in, b_hold), 2*DIGITS-1 bits
  - acc_out <= acc_in ^ p[DIGITS-1:0] ^ c, where c = 0 if in_first else carry
  - carry <= p[2*DIGITS-2:DIGITS]
  - out_valid <= 1; out_first <= in_first; out_last <= 0; a_out <= a_in
- Latency: one cycle from input beat to output beat.
- Beat acceptance:
  - LOADED, in_valid & in_first: accept; counter <= 1; go to RUN, or to DRAIN if in_last is also set (single-beat stream).
  - LOADED, in_valid without in_first: drop; set err[1].
  - RUN, in_valid: accept; counter++; in_last -> DRAIN.
  - RUN, in_valid & in_first: set err[1], then accept as a restart (c=0, counter <= 1).
  - RUN, in_valid=0 (bubble): out_valid <= 0; carry, counter and state hold.
  - IDLE, in_valid: drop; set err[1].
- Drain (one cycle in DRAIN):
  - acc_out <= {0, carry}; a_out <= 0
  - out_valid <= 1; out_last <= 1; out_first <= 0
  - then carry <= 0; go to LOADED (b_hold retained)
  - in_valid during DRAIN: drop; set err[1]
- Output stream length is therefore N+1 for N input beats.
- Length overrun: an accepted beat with counter == NUM_DIGITS and no in_last sets err[0] and forces DRAIN as if in_last were asserted.
- err is cleared only by reset.
- Simultaneous b_load and accepted beat in LOADED: the beat uses the old b_hold; the new value is visible on the next beat.

Optional Feature:
GF2M_PE_PARITY_EN:
- Defined:
  - acc_par_out <= ^acc_out next value, registered with acc_out
  - on each accepted beat, acc_par_in != ^acc_in sets a third sticky bit, reported by OR-ing it into err[1]
- Undefined: acc_par_out is tied 0 and acc_par_in is ignored.

Decomposition:
- Package gf2m_pe_pkg holds:
  - state enum type pe_state_t (IDLE=0, LOADED=1, RUN=2, DRAIN=3)
  - err bit index constants ERR_LEN=0, ERR_PROTO=1
  - default DIGITS and NUM_DIGITS constants
- One sub-module, gf2m_clmul_core: purely combinational DIGITS x DIGITS carry-less multiplier, output 2*DIGITS-1 bits. Instantiated once.

Test Plan:
All scenarios use DIGITS=4, NUM_DIGITS=3.
1. Single-beat stream: b_load b_in=0x3; then one beat with first&last, a_in=0xF, acc_in=0x0 -> out beat acc_out=0x1 with out_first=1; next cycle drain beat acc_out=0x1 with out_last=1; busy returns to 0.
2. Two-beat stream with a bubble: b=0x2, beats a=0x8, then idle cycle, then a=0x8 last, acc_in=0 -> outputs 0x0, (bubble, out_valid=0), 0x1, drain 0x1.
3. Accumulate: as scenario 1 but acc_in=0xA -> out beat 0xB, drain 0x1.
4. Overrun: 4 beats without in_last, b=0x1, a=0x5 each -> three outputs 0x5, then err[0]=1 and drain 0x0 forced after beat 3; the 4th beat arrives during DRAIN -> dropped, err[1]=1.
5. Protocol errors: in_valid in IDLE -> err[1]=1, no output. b_load mid-RUN with b_in=0xF -> ignored; products continue using the old b_hold.
6. Reset mid-RUN: deassert rstn after beat 1 -> all outputs 0 immediately, no drain beat. With GF2M_PE_PARITY_EN defined, wrong acc_par_in -> err[1]=1 and acc_par_out = ^acc_out.
